// File: rtl/fp_ci_initiator_pkg.sv
// Shared types for the FP custom-instruction initiator:
// op-codes, FSM states, request bundle and the abort result.
package fp_ci_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_DIV = 3'd3
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ABORT,
      S_RESP
   } state_e;

   // op is kept as raw bits so codes 4-7 travel unchanged
   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
   } req_t;

   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fp_ci_initiator_if.sv
// Caller-side request/response bundle and the
// FP-unit custom-instruction bundle.
interface fp_req_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  req_tag;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_tag;
   logic        rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b,
      output req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_result,
      input  rsp_tag, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b,
      input  req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_result,
      output rsp_tag, rsp_err
   );
endinterface

interface fp_ci_if;
   logic        ci_clk_en;
   logic        ci_start;
   logic [31:0] ci_dataa;
   logic [31:0] ci_datab;
   logic [2:0]  ci_n;
   logic        ci_reset_req;
   logic        ci_done;
   logic [31:0] ci_result;

   modport master (
      output ci_clk_en, ci_start, ci_dataa,
      output ci_datab, ci_n, ci_reset_req,
      input  ci_done, ci_result
   );

   modport slave (
      input  ci_clk_en, ci_start, ci_dataa,
      input  ci_datab, ci_n, ci_reset_req,
      output ci_done, ci_result
   );
endinterface

// File: rtl/fp_ci_initiator_fifo.sv
// Synchronous request FIFO; DEPTH must be a power of two.
// Caller never pops when empty nor pushes when full without a pop.
module fp_req_fifo
   import fp_ci_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_push,
   input  req_t i_data,
   input  logic i_pop,
   output req_t o_data,
   output logic o_full,
   output logic o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   req_t          r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_cnt;

   // storage write, no reset needed on the data array
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr] <= i_data;
   end

   // pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + PTR_ONE;
         if (i_pop)  r_rd <= r_rd + PTR_ONE;
         if (i_push && !i_pop)
            r_cnt <= r_cnt + CNT_ONE;
         else if (!i_push && i_pop)
            r_cnt <= r_cnt - CNT_ONE;
      end
   end

   assign o_data  = r_mem[r_rd];
   assign o_full  = (r_cnt == CNT_MAX);
   assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/fp_ci_initiator.sv
// Queues FP requests and issues them one at a time to a
// custom-instruction FP unit, with timeout abort.
module fp_ci_initiator
   import fp_ci_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic     clk,
   input logic     reset,
   fp_req_if.slave rq,
   fp_ci_if.master ci
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

   state_e        r_state;
   state_e        w_next;
   req_t          r_op;
   req_t          w_head;
   req_t          w_wr_data;
   logic [CW-1:0] r_cnt;
   logic          r_rsp_valid;
   logic          r_rsp_err;
   logic [31:0]   r_rsp_result;
   logic [3:0]    r_rsp_tag;

   logic w_push;
   logic w_pop;
   logic w_full;
   logic w_empty;
   logic w_done_cap;
   logic w_abort_cap;
   logic w_rsp_clr;
   logic w_cnt_load;
   logic w_cnt_inc;

   assign w_wr_data = '{
      op:  rq.req_op,
      a:   rq.req_a,
      b:   rq.req_b,
      tag: rq.req_tag
   };

   // a pop frees a slot in the same cycle, so full+pop still accepts
   assign rq.req_ready = !reset && (!w_full || w_pop);
   assign w_push       = rq.req_valid && rq.req_ready;

   fp_req_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_wr_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // next state and per-state control strobes
   always_comb begin
      w_next      = r_state;
      w_pop       = 1'b0;
      w_done_cap  = 1'b0;
      w_abort_cap = 1'b0;
      w_rsp_clr   = 1'b0;
      w_cnt_load  = 1'b0;
      w_cnt_inc   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!w_empty && !r_rsp_valid) begin
               w_pop  = 1'b1;
               w_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (ci.ci_done) begin
               w_done_cap = 1'b1;
               w_next     = S_RESP;
            end else begin
               w_cnt_load = 1'b1;
               w_next     = S_WAIT;
            end
         end
         S_WAIT: begin
            // done beats the timeout on the final count
            if (ci.ci_done) begin
               w_done_cap = 1'b1;
               w_next     = S_RESP;
            end else if (r_cnt == CNT_MAX) begin
               w_next = S_ABORT;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_ABORT: begin
            w_abort_cap = 1'b1;
            w_next      = S_RESP;
         end
         S_RESP: begin
            if (rq.rsp_ready) begin
               w_rsp_clr = 1'b1;
               w_next    = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // operand, timeout counter and response registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op         <= '0;
         r_cnt        <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_err    <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_tag    <= '0;
      end else begin
         if (w_pop) r_op <= w_head;

         if (w_cnt_load)
            r_cnt <= CNT_ONE;
         else if (w_cnt_inc)
            r_cnt <= r_cnt + CNT_ONE;
         else if (w_done_cap || w_abort_cap)
            r_cnt <= '0;

         if (w_done_cap) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_err    <= 1'b0;
            r_rsp_result <= ci.ci_result;
            r_rsp_tag    <= r_op.tag;
         end else if (w_abort_cap) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_err    <= 1'b1;
            r_rsp_result <= FP_QNAN;
            r_rsp_tag    <= r_op.tag;
         end else if (w_rsp_clr) begin
            r_rsp_valid  <= 1'b0;
         end
      end
   end

   assign rq.rsp_valid  = r_rsp_valid;
   assign rq.rsp_err    = r_rsp_err;
   assign rq.rsp_result = r_rsp_result;
   assign rq.rsp_tag    = r_rsp_tag;

   assign ci.ci_clk_en    = !reset;
   assign ci.ci_start     = (r_state == S_ISSUE);
   assign ci.ci_reset_req = (r_state == S_ABORT);
   assign ci.ci_dataa     = r_op.a;
   assign ci.ci_datab     = r_op.b;
   assign ci.ci_n         = r_op.op;

endmodule

// File: tb/tb_fp_ci_initiator.sv
// Directed bench: scoreboard of responses plus an FP-unit
// model that checks issued operands and drives done.
module tb_fp_ci_initiator;
   import fp_ci_pkg::*;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  tag;
      logic        err;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  n;
      logic [31:0] res;
      int          dly;
   } slv_t;

   logic clk;
   logic reset;
   logic hold_rdy;

   int n_cmp = 0;
   int n_bad = 0;
   int n_rr  = 0;

   exp_t sb[$];
   slv_t sq[$];

   slv_t cur;
   int   act;
   int   k;
   exp_t mon_e;
   logic mon_rdy;

   fp_req_if rq_if ();
   fp_ci_if  ci_if ();

   fp_ci_initiator #(
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .rq    (rq_if),
      .ci    (ci_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: no finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   task automatic send(
      input logic [2:0]  op,
      input logic [31:0] a,
      input logic [31:0] b,
      input logic [3:0]  tag,
      input logic [31:0] res,
      input int          dly,
      input logic        err
   );
      int g;
      slv_t s;
      g = 0;
      while (!rq_if.req_ready && g < 300) begin
         @(negedge clk);
         g++;
      end
      check("req_ready_wait", rq_if.req_ready, 1);
      rq_if.req_valid = 1'b1;
      rq_if.req_op    = op;
      rq_if.req_a     = a;
      rq_if.req_b     = b;
      rq_if.req_tag   = tag;
      sb.push_back('{res: res, tag: tag, err: err});
      s.a = a;
      s.b = b;
      s.n = op;
      s.res = res;
      s.dly = dly;
      sq.push_back(s);
      @(negedge clk);
      rq_if.req_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int g;
      g = 0;
      while (!rq_if.rsp_valid && g < 300) begin
         @(negedge clk);
         g++;
      end
      check("rsp_arrives", rq_if.rsp_valid, 1);
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb.size() != 0 && g < 2000) begin
         @(negedge clk);
         g++;
      end
      check("drain", sb.size(), 0);
   endtask

   // FP-unit model
   initial begin
      act = 0;
      k = 0;
      ci_if.ci_done   = 1'b0;
      ci_if.ci_result = 32'hDEAD_BEEF;
      forever begin
         @(negedge clk);
         ci_if.ci_done   = 1'b0;
         ci_if.ci_result = 32'hDEAD_BEEF;
         if (reset) begin
            act = 0;
         end else begin
            if (ci_if.ci_reset_req) n_rr++;
            if (act != 0) begin
               k++;
               check("start_once", ci_if.ci_start, 0);
               check("dataa_hold", ci_if.ci_dataa, cur.a);
               check("datab_hold", ci_if.ci_datab, cur.b);
               check("n_hold", ci_if.ci_n, cur.n);
               if (cur.dly < 0) begin
                  if (ci_if.ci_reset_req) begin
                     check("abort_cycle", k, 65);
                     act = 0;
                  end else if (k > 200) begin
                     check("abort_seen", ci_if.ci_reset_req, 1);
                     act = 0;
                  end
               end else if (k == cur.dly) begin
                  ci_if.ci_done   = 1'b1;
                  ci_if.ci_result = cur.res;
                  act = 0;
               end
            end else if (ci_if.ci_start) begin
               if (sq.size() == 0) begin
                  check("spurious_start", ci_if.ci_start, 0);
               end else begin
                  cur = sq.pop_front();
                  k = 0;
                  check("dataa", ci_if.ci_dataa, cur.a);
                  check("datab", ci_if.ci_datab, cur.b);
                  check("n", ci_if.ci_n, cur.n);
                  if (cur.dly == 0) begin
                     ci_if.ci_done   = 1'b1;
                     ci_if.ci_result = cur.res;
                  end else begin
                     act = 1;
                  end
               end
            end
         end
      end
   end

   // response consumer and scoreboard compare
   initial begin
      rq_if.rsp_ready = 1'b0;
      forever begin
         @(negedge clk);
         mon_rdy = !hold_rdy;
         rq_if.rsp_ready = mon_rdy;
         if (rq_if.rsp_valid && mon_rdy) begin
            if (sb.size() == 0) begin
               check("spurious_rsp", rq_if.rsp_valid, 0);
            end else begin
               mon_e = sb.pop_front();
               check("rsp_result", rq_if.rsp_result, mon_e.res);
               check("rsp_tag", rq_if.rsp_tag, mon_e.tag);
               check("rsp_err", rq_if.rsp_err, mon_e.err);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      hold_rdy = 1'b0;
      rq_if.req_valid = 1'b0;
      rq_if.req_op    = '0;
      rq_if.req_a     = '0;
      rq_if.req_b     = '0;
      rq_if.req_tag   = '0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", rq_if.req_ready, 0);
      check("rst_clk_en", ci_if.ci_clk_en, 0);
      check("rst_rsp_valid", rq_if.rsp_valid, 0);
      check("rst_rsp_result", rq_if.rsp_result, 0);
      check("rst_ci_start", ci_if.ci_start, 0);
      check("rst_ci_dataa", ci_if.ci_dataa, 0);
      reset = 1'b0;
      @(negedge clk);
      check("run_req_ready", rq_if.req_ready, 1);
      check("run_clk_en", ci_if.ci_clk_en, 1);

      // 2.5 + 3.0, done on the 4th cycle after issue
      send(OP_ADD, 32'h4020_0000, 32'h4040_0000, 4'd5,
           32'h40B0_0000, 4, 1'b0);
      drain();

      // zero-wait done and done on the last WAIT count
      send(OP_SUB, 32'h3F80_0000, 32'h4000_0000, 4'd1,
           32'hBF80_0000, 0, 1'b0);
      send(OP_MUL, 32'h4000_0000, 32'h4040_0000, 4'd2,
           32'h40C0_0000, 64, 1'b0);
      drain();

      // timeout abort then a normal request
      send(OP_DIV, 32'h4120_0000, 32'h0000_0000, 4'd3,
           FP_QNAN, -1, 1'b1);
      send(OP_ADD, 32'h1111_1111, 32'h2222_2222, 4'd4,
           32'h3333_3333, 1, 1'b0);
      drain();
      check("reset_req_pulses", n_rr, 1);

      // back-pressure: first in flight, four buffered
      send(3'd0, 32'hA000_0000, 32'hB000_0000, 4'd0,
           32'hC000_0000, 20, 1'b0);
      send(3'd1, 32'hA000_0001, 32'hB000_0001, 4'd1,
           32'hC000_0001, 2, 1'b0);
      send(3'd6, 32'hA000_0002, 32'hB000_0002, 4'd2,
           32'hC000_0002, 2, 1'b0);
      send(3'd2, 32'hA000_0003, 32'hB000_0003, 4'd3,
           32'hC000_0003, 2, 1'b0);
      send(3'd3, 32'hA000_0004, 32'hB000_0004, 4'd4,
           32'hC000_0004, 2, 1'b0);
      check("full_not_ready", rq_if.req_ready, 0);
      wait_rsp();
      check("full_in_resp", rq_if.req_ready, 0);
      @(negedge clk);
      check("full_pop_ready", rq_if.req_ready, 1);
      send(3'd7, 32'hA000_0005, 32'hB000_0005, 4'd10,
           32'hC000_0005, 1, 1'b0);
      check("full_again", rq_if.req_ready, 0);
      drain();

      // response stall holds outputs and blocks issue
      hold_rdy = 1'b1;
      send(OP_MUL, 32'h5555_0000, 32'h6666_0000, 4'd7,
           32'h0BAD_F00D, 1, 1'b0);
      send(OP_SUB, 32'h5555_0001, 32'h6666_0001, 4'd8,
           32'h0BAD_F00E, 1, 1'b0);
      wait_rsp();
      for (int i = 0; i < 10; i++) begin
         check("stall_valid", rq_if.rsp_valid, 1);
         check("stall_result", rq_if.rsp_result, 32'h0BAD_F00D);
         check("stall_tag", rq_if.rsp_tag, 7);
         check("stall_err", rq_if.rsp_err, 0);
         check("stall_no_start", ci_if.ci_start, 0);
         @(negedge clk);
      end
      hold_rdy = 1'b0;
      drain();

      // reset in the middle of WAIT with requests queued
      send(3'd5, 32'h7777_0000, 32'h8888_0000, 4'd9,
           FP_QNAN, -1, 1'b1);
      send(OP_ADD, 32'h7777_0001, 32'h8888_0001, 4'd10,
           32'h9999_0001, 1, 1'b0);
      send(OP_ADD, 32'h7777_0002, 32'h8888_0002, 4'd11,
           32'h9999_0002, 1, 1'b0);
      repeat (8) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      sb.delete();
      sq.delete();
      check("mid_rsp_valid", rq_if.rsp_valid, 0);
      check("mid_rsp_result", rq_if.rsp_result, 0);
      check("mid_rsp_tag", rq_if.rsp_tag, 0);
      check("mid_rsp_err", rq_if.rsp_err, 0);
      check("mid_ci_start", ci_if.ci_start, 0);
      check("mid_reset_req", ci_if.ci_reset_req, 0);
      check("mid_dataa", ci_if.ci_dataa, 0);
      check("mid_datab", ci_if.ci_datab, 0);
      check("mid_n", ci_if.ci_n, 0);
      check("mid_req_ready", rq_if.req_ready, 0);
      check("mid_clk_en", ci_if.ci_clk_en, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check("flushed_no_rsp", rq_if.rsp_valid, 0);
      check("flushed_no_start", ci_if.ci_start, 0);
      send(OP_SUB, 32'h4444_0000, 32'h4444_0001, 4'd12,
           32'h4444_0002, 2, 1'b0);
      drain();

      check("sq_empty", sq.size(), 0);
      check("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fp_ci_initiator.md
FP_CI_INITIATOR -- requirements
Module: fp_ci_initiator

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: request FIFO entries; power of two, at least 2.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: maximum cycles in WAIT before abort.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  request offered.
REQ-006 req_ready  out  1  request FIFO not full.
REQ-007 req_op  in  3  operation select forwarded as n (0 ADD, 1 SUB, 2 MUL, 3 DIV, 4-7 passed unchanged).
REQ-008 req_a / req_b  in  32  IEEE-754 single operands.
REQ-009 req_tag  in  4  caller tag, returned with the response.
REQ-010 rsp_valid  out  1  response held.
REQ-011 rsp_ready  in  1  response consumed.
REQ-012 rsp_result  out  32  FP result.
REQ-013 rsp_tag  out  4  tag of the completed request.
REQ-014 rsp_err  out  1  1 = timeout abort.
REQ-015 ci_clk_en  out  1  FP-unit clock enable.
REQ-016 ci_start  out  1  one-cycle issue pulse.
REQ-017 ci_dataa / ci_datab  out  32  operands.
REQ-018 ci_n  out  3  operation select.
REQ-019 ci_reset_req  out  1  FP-unit abort request.
REQ-020 ci_done  in  1  FP-unit completion.
REQ-021 ci_result  in  32  FP-unit result, valid while ci_done=1.

Function
REQ-022 Request accepted on a cycle with req_valid & req_ready; it is pushed into the FIFO in order, with no drop or duplicate.
REQ-023 FSM states: IDLE, ISSUE, WAIT, ABORT, RESP.
REQ-024 IDLE -> ISSUE when the FIFO is non-empty and rsp_valid=0; the head entry is popped into the operand registers.
REQ-025 ISSUE: ci_start=1 for exactly one cycle; ci_dataa, ci_datab and ci_n are driven from the registers and held stable until completion or abort.
REQ-026 ci_done=1 in ISSUE or WAIT captures ci_result and the tag into the response register, sets rsp_valid=1 and rsp_err=0, then goes to RESP.
REQ-027 If ci_done=0 in ISSUE, go to WAIT; the timeout counter starts at 1 in the first WAIT cycle.
REQ-028 When the counter reaches TIMEOUT_CYCLES with ci_done=0, go to ABORT.
REQ-029 If ci_done arrives in the same cycle the count reaches TIMEOUT_CYCLES, the done wins and it is a normal completion.
REQ-030 ABORT: ci_reset_req=1 for one cycle; the response register loads result 32'h7FC00000 with rsp_err=1 and rsp_valid=1; go to RESP.
REQ-031 RESP: hold all rsp_* stable while rsp_valid & !rsp_ready; on rsp_ready, clear rsp_valid and go to IDLE.
REQ-032 Issue-to-issue is at least 3 cycles (ISSUE, RESP, IDLE); there is one request in flight at most.
REQ-033 ci_clk_en=1 whenever reset=0.
REQ-034 ci_done outside ISSUE/WAIT is ignored.
REQ-035 Push and pop in the same cycle are legal when the FIFO is full; the count is unchanged and req_ready stays 1 that cycle only if a pop occurs.

Reset
REQ-036 Reset asserted at any time, including mid-WAIT: FSM=IDLE, FIFO emptied, counter=0.
REQ-037 Reset values: rsp_valid=0, rsp_err=0, rsp_result=0, rsp_tag=0, ci_start=0, ci_reset_req=0, ci_dataa=0, ci_datab=0, ci_n=0, req_ready=0 while reset=1, ci_clk_en=0 while reset=1.
REQ-038 The first request is accepted no earlier than the first rising edge after reset deasserts.

Structure
REQ-039 Shared package fp_ci_pkg holds: the op-code enum (ADD/SUB/MUL/DIV), the state enum, the request struct {op, a, b, tag}, and the constant FP_QNAN=32'h7FC00000.
REQ-040 Sub-module fp_req_fifo: synchronous FIFO of request structs with full/empty flags; the rest is inline.

Verification
REQ-041 Add: a=0x40200000 (2.5), b=0x40400000 (3.0), op 0, tag 5; slave done after 4 cycles -> one ci_start pulse, operands stable until done, rsp_result=0x40B00000, rsp_tag=5, rsp_err=0.
REQ-042 Back-pressure: 5 requests pushed while ci_done is stalled -> req_ready drops after the 4th is buffered (FIFO_DEPTH=4; the first is popped into flight); responses return in tag order 0..4.
REQ-043 Timeout: slave never asserts done -> ci_reset_req pulses once 64 WAIT cycles after the first WAIT cycle; rsp_result=0x7FC00000, rsp_err=1; the next request issues normally.
REQ-044 Boundary: done in ISSUE (zero wait) and done on WAIT cycle 64 -> both are normal completions with rsp_err=0.
REQ-045 rsp_ready held 0 for 10 cycles -> rsp_* stable and no new ci_start until consumed.
REQ-046 Reset asserted mid-WAIT -> all outputs at reset values asynchronously; the queued requests are discarded.
